sym_decim: RTL and testbench

//  Receive-side counterpart to the transmit clock-enable scheme: consumes the sample and

---
 rtl/sym_decim.sv | 111 +++++++++++
 tb/tb_sym_decim.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sym_decim.sv
// Symbol decimator: keeps one selected sample phase per symbol and flags strobe misalignment.
// Optional slicer decision output is enabled by defining SYM_DECIM_SLICER_EN.
module sym_decim #(
    parameter int WIDTH  = 18,
    parameter int SPS    = 4,
    parameter int PH_W   = 2,
    parameter int THRESH = 65536
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic [PH_W-1:0]         phase_sel,
    input  logic                    clr_err,
    output logic signed [WIDTH-1:0] sym_out,
    output logic                    sym_valid,
    output logic [1:0]              sym_dec,
    output logic                    align_err,
    output logic [15:0]             sym_cnt
);

    logic [PH_W-1:0]         ph_reg, ph_next;
    logic [PH_W-1:0]         phase_q_reg;
    logic signed [WIDTH-1:0] hold_reg;
    logic                    primed_reg;
    logic signed [WIDTH-1:0] sym_out_reg;
    logic                    sym_valid_reg;
    logic [1:0]              sym_dec_reg;
    logic                    align_err_reg;
    logic [15:0]             sym_cnt_reg;

    logic [PH_W-1:0] eph;
    logic            capture;
    logic            release_sym;
    logic            align_set;
    logic [1:0]      dec_next;

    // Gray decision around +/-THRESH, from the value being released
    function automatic logic [1:0] slice(input logic signed [WIDTH-1:0] v);
        if (int'(v) >= THRESH)
            return 2'b10;
        else if (int'(v) >= 0)
            return 2'b11;
        else if (int'(v) >= -THRESH)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        eph         = sym_clk_en ? '0 : ph_reg;
        capture     = sam_clk_en && (eph == phase_q_reg);
        release_sym = sym_clk_en && primed_reg;
        align_set   = (sym_clk_en && sam_clk_en && (ph_reg != '0))
                   || (sym_clk_en && !sam_clk_en)
                   || (sam_clk_en && !sym_clk_en && (ph_reg == '0));
        ph_next     = ph_reg;
        if (sam_clk_en)
            ph_next = (eph == PH_W'(SPS - 1)) ? '0 : eph + PH_W'(1);
        else if (sym_clk_en)
            ph_next = '0;
`ifdef SYM_DECIM_SLICER_EN
        dec_next = slice(hold_reg);
`else
        dec_next = 2'b00;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_reg        <= '0;
            phase_q_reg   <= '0;
            hold_reg      <= '0;
            primed_reg    <= 1'b0;
            sym_out_reg   <= '0;
            sym_valid_reg <= 1'b0;
            sym_dec_reg   <= 2'b00;
            align_err_reg <= 1'b0;
            sym_cnt_reg   <= '0;
        end else begin
            ph_reg <= ph_next;
            if (sym_clk_en)
                phase_q_reg <= phase_sel;
            if (capture)
                hold_reg <= x_in;
            // a recapture on the releasing edge keeps the decimator primed
            if (capture)
                primed_reg <= 1'b1;
            else if (sym_clk_en)
                primed_reg <= 1'b0;
            sym_valid_reg <= release_sym;
            if (release_sym) begin
                sym_out_reg <= hold_reg;
                sym_dec_reg <= dec_next;
                sym_cnt_reg <= sym_cnt_reg + 16'd1;
            end
            if (align_set)
                align_err_reg <= 1'b1;
            else if (clr_err)
                align_err_reg <= 1'b0;
        end
    end

    assign sym_out   = sym_out_reg;
    assign sym_valid = sym_valid_reg;
    assign sym_dec   = sym_dec_reg;
    assign align_err = align_err_reg;
    assign sym_cnt   = sym_cnt_reg;

endmodule

// File: tb/tb_sym_decim.sv
// Directed plus randomized bench for sym_decim against a sample-counting reference model.
module tb_sym_decim;

    localparam int SPS    = 4;
    localparam int THRESH = 65536;

    logic               clk = 1'b0;
    logic               reset;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic signed [17:0] x_in;
    logic [1:0]         phase_sel;
    logic               clr_err;
    logic signed [17:0] sym_out;
    logic               sym_valid;
    logic [1:0]         sym_dec;
    logic               align_err;
    logic [15:0]        sym_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int                 m_n;
    int                 m_phase;
    logic signed [17:0] m_pend[$];
    logic signed [17:0] e_out;
    logic               e_valid;
    logic [1:0]         e_dec;
    logic               e_err;
    logic [15:0]        e_cnt;

    sym_decim dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .x_in       (x_in),
        .phase_sel  (phase_sel),
        .clr_err    (clr_err),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .sym_dec    (sym_dec),
        .align_err  (align_err),
        .sym_cnt    (sym_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_slice(input int v);
        if (v >= THRESH)       return 2'b10;
        else if (v >= 0)       return 2'b11;
        else if (v >= -THRESH) return 2'b01;
        else                   return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("sym_valid", 32'(sym_valid), 32'(e_valid));
        chk("sym_out",   32'(sym_out),   32'(e_out));
        chk("sym_cnt",   32'(sym_cnt),   32'(e_cnt));
        chk("align_err", 32'(align_err), 32'(e_err));
        chk("sym_dec",   32'(sym_dec),   32'(e_dec));
    endtask

    task automatic m_reset();
        m_n = 0; m_phase = 0; m_pend.delete();
        e_out = '0; e_valid = 1'b0; e_dec = 2'b00; e_err = 1'b0; e_cnt = '0;
    endtask

    // One clock: drive inputs, advance the model, check outputs 1 time unit after the edge.
    task automatic step(input bit sam, input bit sym, input logic signed [17:0] x,
                        input int psel, input bit clr);
        int  pos;
        bit  set;
        sam_clk_en = sam; sym_clk_en = sym; x_in = x; phase_sel = 2'(psel); clr_err = clr;
        pos = m_n % SPS;
        set = (sym && sam && pos != 0) || (sym && !sam) || (sam && !sym && pos == 0);
        e_valid = 1'b0;
        if (sym) begin
            if (m_pend.size() > 0) begin
                e_out   = m_pend[0];
                e_valid = 1'b1;
                e_cnt   = e_cnt + 16'd1;
`ifdef SYM_DECIM_SLICER_EN
                e_dec   = ref_slice(int'(e_out));
`endif
            end
            m_pend.delete();
        end
        if (sam && (sym ? 0 : pos) == m_phase)
            m_pend = '{x};
        if (sym) m_phase = psel;
        if (sam) m_n = sym ? 1 : m_n + 1;
        else if (sym) m_n = 0;
        if (set) e_err = 1'b1;
        else if (clr) e_err = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_sample(input logic signed [17:0] x, input bit sym,
                               input int psel, input bit clr);
        step(1'b1, sym, x, psel, clr);
        for (int i = 0; i < SPS - 1; i++)
            step(1'b0, 1'b0, 18'($urandom), psel, 1'b0);
    endtask

    int n;
    logic signed [17:0] slv[7];

    initial begin
        reset = 1'b0; sam_clk_en = 0; sym_clk_en = 0; x_in = '0; phase_sel = '0; clr_err = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // nominal ramp, phase 2: expect 2,6,10,...; first strobe releases nothing
        n = 0;
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < SPS; k++) begin
                send_sample(18'(n), k == 0, 2, 1'b0);
                n++;
            end

        // phase_sel 1 -> 3 mid-symbol takes effect one symbol later
        send_sample(18'(n), 1'b1, 1, 1'b0); n++;
        send_sample(18'(n), 1'b0, 3, 1'b0); n++;
        send_sample(18'(n), 1'b0, 3, 1'b0); n++;
        send_sample(18'(n), 1'b0, 3, 1'b0); n++;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < SPS; k++) begin
                send_sample(18'(n), k == 0, 3, 1'b0);
                n++;
            end

        // dropped symbol strobe: error on 5th sample, clear loses to a same-cycle set
        send_sample(18'(n), 1'b1, 0, 1'b0); n++;
        for (int k = 1; k < 8; k++) begin
            send_sample(18'(n), 1'b0, 0, 1'b0); n++;
        end
        send_sample(18'(n), 1'b0, 0, 1'b1); n++;
        for (int k = 0; k < 3; k++) begin
            send_sample(18'(n), 1'b0, 0, 1'b0); n++;
        end
        step(1'b0, 1'b0, '0, 0, 1'b1);
        send_sample(18'(n), 1'b1, 2, 1'b0); n++;
        // symbol strobe with no sample strobe
        step(1'b0, 1'b1, '0, 2, 1'b0);
        step(1'b0, 1'b0, '0, 2, 1'b1);

        // reset during phase 2 of symbol 5
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < SPS; k++) begin
                send_sample(18'(n), k == 0, 2, 1'b0); n++;
            end
        send_sample(18'(n), 1'b1, 2, 1'b0); n++;
        send_sample(18'(n), 1'b0, 2, 1'b0); n++;
        step(1'b1, 1'b0, 18'(n), 2, 1'b0); n++;
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < SPS; k++) begin
                send_sample(18'(n), k == 0, 2, 1'b0); n++;
            end

        // slicer thresholds via phase 0 captures
        slv[0] = 18'sd98304;  slv[1] = 18'sd32768;  slv[2] = -18'sd32768;
        slv[3] = -18'sd98304; slv[4] = 18'sd65536;  slv[5] = -18'sd65536;
        slv[6] = 18'sd0;
        for (int s = 0; s < 7; s++)
            for (int k = 0; k < SPS; k++)
                send_sample(k == 0 ? slv[s] : 18'($urandom), k == 0, 0, 1'b0);

        // randomized symbols, phases, clears and occasional dropped strobes
        for (int s = 0; s < 40; s++) begin
            int psel;
            psel = int'($urandom_range(0, SPS - 1));
            for (int k = 0; k < SPS; k++)
                send_sample(18'($urandom), (k == 0) && ($urandom_range(0, 9) != 0),
                            (k == 0) ? psel : int'($urandom_range(0, SPS - 1)),
                            $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
